// File: rtl/sm3_result_serializer.sv
// Serializes a captured 256-bit SM3 digest into eight 32-bit words over a valid/ready stream.
// Word 0 is the most significant word; byte order within a word is optionally reversed.
module sm3_result_serializer #(
    parameter bit BYTE_SWAP = 1'b0
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    input  logic [255:0] sm3_result_in,
    input  logic         sm3_finished_in,
    input  logic         clear_in,
    output logic [31:0]  word_out,
    output logic         word_valid_out,
    input  logic         word_ready_in,
    output logic         word_last_out,
    output logic [2:0]   word_index_out,
    output logic         busy_out,
    output logic         overrun_out
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DIGEST_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic                ovr_q, ovr_d;
    logic                xfer;

    // Word k of a digest, most significant word first, with optional byte reversal.
    function automatic logic [WORD_W-1:0] pick_word(input logic [DIGEST_W-1:0] d,
                                                    input logic [IDX_W-1:0]    k);
        logic [WORD_W-1:0] w;
        w = d[WORD_W*(LAST_IDX - 32'(k)) +: WORD_W];
        if (BYTE_SWAP) begin
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        return w;
    endfunction

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        ovr_d   = ovr_q;
        xfer    = (state_q == SEND) && word_ready_in;

        if (clear_in) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sm3_finished_in) begin
                        state_d = SEND;
                        data_d  = sm3_result_in;
                        idx_d   = '0;
                        word_d  = pick_word(sm3_result_in, '0);
                        last_d  = 1'b0;
                    end
                end
                SEND: begin
                    if (xfer && (idx_q == IDX_W'(LAST_IDX))) begin
                        // Final word leaves; a coincident digest chains straight in.
                        idx_d  = '0;
                        last_d = 1'b0;
                        if (sm3_finished_in) begin
                            data_d = sm3_result_in;
                            word_d = pick_word(sm3_result_in, '0);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            idx_d  = idx_q + IDX_W'(1);
                            word_d = pick_word(data_q, idx_q + IDX_W'(1));
                            last_d = (idx_q == IDX_W'(LAST_IDX - 1));
                        end
                        if (sm3_finished_in) begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign word_out       = word_q;
    assign word_valid_out = (state_q == SEND);
    assign word_last_out  = last_q;
    assign word_index_out = idx_q;
    assign busy_out       = (state_q == SEND);
    assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_sm3_result_serializer.sv
// Bench for sm3_result_serializer: directed scenarios plus random traffic against a queue model.
module tb_sm3_result_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] result;
    logic         fin;
    logic         clr;
    logic         rdy;

    logic [31:0]  word_out, sw_word_out;
    logic         word_valid_out, sw_valid_out;
    logic         word_last_out, sw_last_out;
    logic [2:0]   word_index_out, sw_index_out;
    logic         busy_out, sw_busy_out;
    logic         overrun_out, sw_overrun_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending words (front = current), their indices, sticky overrun.
    logic [31:0] mq[$];
    logic [2:0]  mi[$];
    bit          m_ovr;

    localparam logic [255:0] ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] D2  = 256'h01234567_89abcdef_fedcba98_76543210_a5a5a5a5_5a5a5a5a_deadbeef_cafef00d;
    logic [31:0] abc_w[8] = '{32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                              32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
    logic [31:0] d2_w0 = 32'h01234567;

    sm3_result_serializer #(.BYTE_SWAP(1'b0)) dut (
        .clk_in(clk), .reset_n_in(rst_n), .sm3_result_in(result), .sm3_finished_in(fin),
        .clear_in(clr), .word_out(word_out), .word_valid_out(word_valid_out),
        .word_ready_in(rdy), .word_last_out(word_last_out), .word_index_out(word_index_out),
        .busy_out(busy_out), .overrun_out(overrun_out)
    );

    sm3_result_serializer #(.BYTE_SWAP(1'b1)) dut_sw (
        .clk_in(clk), .reset_n_in(rst_n), .sm3_result_in(result), .sm3_finished_in(fin),
        .clear_in(clr), .word_out(sw_word_out), .word_valid_out(sw_valid_out),
        .word_ready_in(rdy), .word_last_out(sw_last_out), .word_index_out(sw_index_out),
        .busy_out(sw_busy_out), .overrun_out(sw_overrun_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {<<8{w}};
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then settle.
    task automatic cyc();
        int  n;
        bit  xf;
        @(posedge clk);
        n = mq.size();
        if (!rst_n || clr) begin
            mq.delete();
            mi.delete();
            m_ovr = 1'b0;
        end else begin
            xf = (n > 0) && rdy;
            if (xf) begin
                void'(mq.pop_front());
                void'(mi.pop_front());
            end
            if (fin) begin
                if (n == 0 || (xf && n == 1)) begin
                    for (int k = 0; k < 8; k++) begin
                        mq.push_back(result[32*(7-k) +: 32]);
                        mi.push_back(3'(k));
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fin = 1'b0; clr = 1'b0; rdy = 1'b0; result = '0;
        cyc(); cyc();
        n_checks++;
        if ({word_out, word_valid_out, word_last_out, word_index_out, busy_out, overrun_out} !== '0)
            begin n_errors++; $display("FAIL reset_outputs got w=%h v=%b l=%b i=%0d b=%b o=%b want all 0",
                word_out, word_valid_out, word_last_out, word_index_out, busy_out, overrun_out); end
        n_checks++;
        if ({sw_word_out, sw_valid_out, sw_busy_out, sw_overrun_out} !== '0)
            begin n_errors++; $display("FAIL reset_swap_outputs got w=%h v=%b want 0", sw_word_out, sw_valid_out); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_abc();
        fin = 1'b1; result = ABC; rdy = 1'b1;
        cyc();
        fin = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (word_valid_out !== 1'b1 || word_out !== abc_w[k] || word_index_out !== 3'(k) ||
                word_last_out !== (k == 7) || busy_out !== 1'b1)
                begin n_errors++; $display("FAIL abc_word%0d got v=%b w=%h i=%0d l=%b want v=1 w=%h i=%0d l=%b",
                    k, word_valid_out, word_out, word_index_out, word_last_out, abc_w[k], k, k == 7); end
            if (k == 0) begin
                n_checks++;
                if (sw_word_out !== 32'hf4f0c766)
                    begin n_errors++; $display("FAIL swap_first got %h want f4f0c766", sw_word_out); end
            end
            if (k == 7) begin
                n_checks++;
                if (sw_word_out !== 32'he0a84b8f || sw_last_out !== 1'b1)
                    begin n_errors++; $display("FAIL swap_last got %h l=%b want e0a84b8f l=1", sw_word_out, sw_last_out); end
            end
            cyc();
        end
        n_checks++;
        if (word_valid_out !== 1'b0 || busy_out !== 1'b0 || word_last_out !== 1'b0)
            begin n_errors++; $display("FAIL abc_done got v=%b b=%b l=%b want 0", word_valid_out, busy_out, word_last_out); end
    endtask

    task automatic test_backpressure();
        int          pat[4] = '{1, 0, 0, 1};
        int          cnt;
        logic [31:0] held;
        bit          hv;
        cnt = 0;
        fin = 1'b1; result = ABC; rdy = 1'b0;
        cyc();
        fin = 1'b0;
        for (int c = 0; c < 40 && cnt < 8; c++) begin
            rdy = pat[c % 4][0];
            if (word_valid_out && rdy) begin
                n_checks++;
                if (word_out !== abc_w[cnt] || word_index_out !== 3'(cnt))
                    begin n_errors++; $display("FAIL bp_transfer%0d got w=%h i=%0d want w=%h i=%0d",
                        cnt, word_out, word_index_out, abc_w[cnt], cnt); end
                cnt++;
            end
            held = word_out;
            hv   = word_valid_out && !rdy;
            cyc();
            if (hv) begin
                n_checks++;
                if (word_out !== held || word_valid_out !== 1'b1)
                    begin n_errors++; $display("FAIL bp_hold got w=%h v=%b want w=%h v=1", word_out, word_valid_out, held); end
            end
        end
        n_checks++;
        if (cnt != 8 || word_valid_out !== 1'b0)
            begin n_errors++; $display("FAIL bp_count got %0d transfers v=%b want 8 v=0", cnt, word_valid_out); end
        rdy = 1'b1;
    endtask

    task automatic test_back_to_back();
        fin = 1'b1; result = ABC; rdy = 1'b1;
        cyc();
        fin = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        n_checks++;
        if (word_index_out !== 3'd7 || word_last_out !== 1'b1)
            begin n_errors++; $display("FAIL b2b_at_last got i=%0d l=%b want 7 1", word_index_out, word_last_out); end
        fin = 1'b1; result = D2;
        cyc();
        fin = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== d2_w0 || word_index_out !== 3'd0 ||
            overrun_out !== 1'b0 || word_last_out !== 1'b0)
            begin n_errors++; $display("FAIL b2b_chain got v=%b w=%h i=%0d o=%b want v=1 w=%h i=0 o=0",
                word_valid_out, word_out, word_index_out, overrun_out, d2_w0); end
        for (int k = 0; k < 8; k++) cyc();
        n_checks++;
        if (word_valid_out !== 1'b0 || overrun_out !== 1'b0)
            begin n_errors++; $display("FAIL b2b_done got v=%b o=%b want 0 0", word_valid_out, overrun_out); end
    endtask

    task automatic test_overrun();
        fin = 1'b1; result = ABC; rdy = 1'b1;
        cyc();
        fin = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        fin = 1'b1; result = D2;
        cyc();
        fin = 1'b0;
        for (int k = 4; k < 8; k++) begin
            n_checks++;
            if (word_out !== abc_w[k] || word_index_out !== 3'(k) || overrun_out !== 1'b1)
                begin n_errors++; $display("FAIL ovr_word%0d got w=%h i=%0d o=%b want w=%h i=%0d o=1",
                    k, word_out, word_index_out, overrun_out, abc_w[k], k); end
            cyc();
        end
        n_checks++;
        if (word_valid_out !== 1'b0 || overrun_out !== 1'b1)
            begin n_errors++; $display("FAIL ovr_sticky got v=%b o=%b want v=0 o=1", word_valid_out, overrun_out); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++;
        if (overrun_out !== 1'b0)
            begin n_errors++; $display("FAIL ovr_clear got %b want 0", overrun_out); end
    endtask

    task automatic test_abort(input bit use_reset);
        fin = 1'b1; result = ABC; rdy = 1'b1;
        cyc();
        fin = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        n_checks++;
        if (word_index_out !== 3'd5)
            begin n_errors++; $display("FAIL abort_pre got i=%0d want 5", word_index_out); end
        if (use_reset) rst_n = 1'b0; else clr = 1'b1;
        fin = 1'b1; result = D2;
        cyc();
        rst_n = 1'b1; clr = 1'b0; fin = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b0 || busy_out !== 1'b0 || word_index_out !== 3'd0 || overrun_out !== 1'b0)
            begin n_errors++; $display("FAIL abort_%s got v=%b b=%b i=%0d o=%b want 0 0 0 0", use_reset ? "rst" : "clr",
                word_valid_out, busy_out, word_index_out, overrun_out); end
        fin = 1'b1; result = D2;
        cyc();
        fin = 1'b0;
        n_checks++;
        if (word_valid_out !== 1'b1 || word_out !== d2_w0 || word_index_out !== 3'd0)
            begin n_errors++; $display("FAIL abort_restart got v=%b w=%h i=%0d want v=1 w=%h i=0",
                word_valid_out, word_out, word_index_out, d2_w0); end
        for (int k = 0; k < 8; k++) cyc();
    endtask

    task automatic test_random();
        bit ev;
        for (int c = 0; c < 3000; c++) begin
            fin   = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) result[32*k +: 32] = $urandom;
            cyc();
            ev = (mq.size() > 0);
            n_checks++;
            if (word_valid_out !== ev || busy_out !== ev || overrun_out !== m_ovr || sw_valid_out !== ev)
                begin n_errors++; $display("FAIL rand_ctrl c=%0d got v=%b b=%b o=%b want v=%b o=%b",
                    c, word_valid_out, busy_out, overrun_out, ev, m_ovr); end
            if (ev) begin
                n_checks++;
                if (word_out !== mq[0] || word_index_out !== mi[0] || word_last_out !== (mi[0] == 3'd7) ||
                    sw_word_out !== swap32(mq[0]))
                    begin n_errors++; $display("FAIL rand_word c=%0d got w=%h i=%0d l=%b sw=%h want w=%h i=%0d",
                        c, word_out, word_index_out, word_last_out, sw_word_out, mq[0], mi[0]); end
            end
        end
        fin = 1'b0; clr = 1'b0; rst_n = 1'b1; rdy = 1'b1;
    endtask

    initial begin
        m_ovr = 1'b0;
        test_reset();
        test_abc();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sm3_result_serializer.md
SM3_RESULT_SERIALIZER -- requirements
Module: sm3_result_serializer

Interface
REQ-001 SHALL have parameter BYTE_SWAP, default 0; 0 = each word output as-is, 1 = byte order within each 32-bit word reversed.
REQ-002 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n_in  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port sm3_result_in  input  256  digest from the hash core; valid only in the cycle sm3_finished_in is high.
REQ-005 SHALL have port sm3_finished_in  input  1  single-cycle pulse marking a completed digest.
REQ-006 SHALL have port clear_in  input  1  synchronous abort and flag clear.
REQ-007 SHALL have port word_out  output  32  current digest word.
REQ-008 SHALL have port word_valid_out  output  1  word_out holds a valid word.
REQ-009 SHALL have port word_ready_in  input  1  consumer accepts word_out.
REQ-010 SHALL have port word_last_out  output  1  high with the 8th word of the digest.
REQ-011 SHALL have port word_index_out  output  3  index 0..7 of the current word.
REQ-012 SHALL have port busy_out  output  1  a digest is captured and not fully sent.
REQ-013 SHALL have port overrun_out  output  1  sticky flag: a digest was dropped.

Function
REQ-014 SHALL use two states: IDLE and SEND.
REQ-015 In IDLE, sm3_finished_in=1 SHALL capture sm3_result_in into a 256-bit holding register, set index to 0 and enter SEND on the next edge.
REQ-016 Latency: word_valid_out SHALL go high in the cycle after the sm3_finished_in pulse, with word 0 on word_out.
REQ-017 Word k (k=0..7) SHALL equal captured bits [255-32k : 224-32k]; word 0 is register A (bits 255:224).
REQ-018 With BYTE_SWAP=1, word_out SHALL be {w[7:0],w[15:8],w[23:16],w[31:24]} of word k.
REQ-019 A transfer SHALL occur only in a cycle where word_valid_out=1 and word_ready_in=1.
REQ-020 While word_valid_out=1 and word_ready_in=0, word_out, word_index_out and word_last_out SHALL be held stable.
REQ-021 On transfer of word k<7, index SHALL advance to k+1 on the next edge, with no idle cycle (throughput one word per cycle).
REQ-022 word_last_out SHALL equal (word_valid_out and index==7).
REQ-023 On transfer of word 7 without a simultaneous sm3_finished_in, the block SHALL return to IDLE and word_valid_out SHALL be 0 in the next cycle.
REQ-024 If sm3_finished_in=1 in the same cycle as the transfer of word 7, the new digest SHALL be captured, state SHALL remain SEND, and word 0 of the new digest SHALL appear the next cycle with word_valid_out held high.
REQ-025 sm3_finished_in=1 in SEND other than as in REQ-024 SHALL be ignored (holding register unchanged) and SHALL set overrun_out=1 on the next edge.
REQ-026 overrun_out SHALL stay 1 until clear_in=1 or reset.
REQ-027 clear_in=1 SHALL, on the next edge, force IDLE, index 0, word_valid_out 0 and overrun_out 0, discarding any partial digest.
REQ-028 clear_in=1 SHALL take priority over a simultaneous sm3_finished_in; that digest SHALL be dropped without setting overrun_out.
REQ-029 busy_out SHALL be 1 exactly when state is SEND.
REQ-030 word_ready_in SHALL have no effect while word_valid_out=0.
REQ-031 All outputs SHALL be driven from registers; no combinational path from word_ready_in to any output.

Reset
REQ-032 reset_n_in=0 at a rising edge SHALL set state IDLE, index 0, holding register 0, and outputs word_out=0, word_valid_out=0, word_last_out=0, word_index_out=0, busy_out=0, overrun_out=0.
REQ-033 Reset SHALL take priority over clear_in and sm3_finished_in, including during SEND; any partial digest is discarded.

Verification
REQ-034 Standard vector: pulse with digest of "abc" (66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0), ready held 1 -> 8 consecutive valid words in that order, index 0..7, last only on 8f4ba8e0, valid low afterwards.
REQ-035 Backpressure: same digest, ready toggling 1,0,0,1,... -> words held stable while ready=0, no word lost or duplicated, 8 transfers total.
REQ-036 Back-to-back: second pulse coincident with transfer of word 7 -> valid stays high, next word is word 0 of second digest, overrun_out stays 0.
REQ-037 Overrun: second pulse while index=3 -> first digest completes unchanged, overrun_out=1 until clear_in pulse, then 0.
REQ-038 BYTE_SWAP=1 with "abc" digest -> first word f4f0c766, last word e0a84b8f.
REQ-039 Reset or clear_in at index=5 -> next cycle valid=0, busy=0, index=0; subsequent pulse serializes from word 0 normally.
